// File: rtl/lab1_pkg.sv
// Shared types and constants for the lab1 key controller / RAM front end.
package lab1_pkg;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned NKEYS  = 4;

  // Key indices into the KEY bus
  localparam int unsigned KEY_DINC = 0;
  localparam int unsigned KEY_DDEC = 1;
  localparam int unsigned KEY_AINC = 2;
  localparam int unsigned KEY_ADEC = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    WRITE  = 2'd2,
    SETTLE = 2'd3
  } state_t;

endpackage

// File: rtl/key_debounce.sv
// Single pushbutton conditioner: 2-flop synchroniser, debounce counter and a
// one-cycle press pulse on the accepted 1->0 transition.
// Optional: KEY_AUTOREPEAT_EN adds a hold-to-repeat counter that emits extra
// press pulses after REPEAT_DELAY cycles, then every REPEAT_PERIOD cycles.
module key_debounce
  import lab1_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,  // legal range >= 2
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  output logic press
);

  localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES);

  logic          sync1, sync2;
  logic          level, level_n;
  logic [DW-1:0] cnt, cnt_n;
  logic          fall_c;
  logic          rep_c;

  // Bring the raw button into the clk domain; released (1) out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= key;
      sync2 <= sync1;
    end
  end

  // Accept a new level only after it has differed for DEBOUNCE_CYCLES cycles
  always_comb begin
    cnt_n   = cnt;
    level_n = level;
    if (sync2 == level) begin
      cnt_n = '0;
    end else if (cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
      cnt_n   = '0;
      level_n = sync2;
    end else begin
      cnt_n = cnt + DW'(1);
    end
    fall_c = level & ~level_n;
  end

`ifdef KEY_AUTOREPEAT_EN
  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RW      = $clog2(REP_MAX + 1);

  logic [RW-1:0] rcnt, rcnt_n;
  logic          rfirst, rfirst_n;

  // Count hold time while pressed; first repeat after the delay, then periodic
  always_comb begin
    rcnt_n   = rcnt;
    rfirst_n = rfirst;
    rep_c    = 1'b0;
    if (level || level_n) begin
      rcnt_n   = '0;
      rfirst_n = 1'b0;
    end else if (!rfirst && rcnt == RW'(REPEAT_DELAY - 1)) begin
      rep_c    = 1'b1;
      rcnt_n   = '0;
      rfirst_n = 1'b1;
    end else if (rfirst && rcnt == RW'(REPEAT_PERIOD - 1)) begin
      rep_c  = 1'b1;
      rcnt_n = '0;
    end else begin
      rcnt_n = rcnt + RW'(1);
    end
  end

  // Repeat counter state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcnt   <= '0;
      rfirst <= 1'b0;
    end else begin
      rcnt   <= rcnt_n;
      rfirst <= rfirst_n;
    end
  end
`else
  assign rep_c = 1'b0;
`endif

  // Debounce state and registered press pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      level <= 1'b1;
      press <= 1'b0;
    end else begin
      cnt   <= cnt_n;
      level <= level_n;
      press <= fall_c | rep_c;
    end
  end

endmodule

// File: rtl/key_controller.sv
// Turns four active-low pushbuttons into RAM address browsing and
// read-modify-write increment/decrement of the stored byte.
// Optional: KEY_AUTOREPEAT_EN enables hold-to-repeat in every key conditioner.
module key_controller
  import lab1_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NKEYS-1:0]  KEY,
  input  logic [DATA_W-1:0] dout,
  output logic [ADDR_W-1:0] a,
  output logic [DATA_W-1:0] din,
  output logic              we
);

  logic [NKEYS-1:0]  evt;
  state_t            state, state_n;
  logic [ADDR_W-1:0] a_n;
  logic [DATA_W-1:0] din_n;
  logic              we_n;
  logic              dir_inc, dir_inc_n;

  // One conditioner per pushbutton
  for (genvar i = 0; i < int'(NKEYS); i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_db (
      .clk   (clk),
      .rst_n (rst_n),
      .key   (KEY[i]),
      .press (evt[i])
    );
  end

  // Next-state and output logic; events outside IDLE and arbitration losers are dropped
  always_comb begin
    state_n   = state;
    a_n       = a;
    din_n     = din;
    we_n      = 1'b0;
    dir_inc_n = dir_inc;
    unique case (state)
      IDLE: begin
        if (evt[KEY_AINC]) begin
          a_n     = a + ADDR_W'(1);
          state_n = SETTLE;
        end else if (evt[KEY_ADEC]) begin
          a_n     = a - ADDR_W'(1);
          state_n = SETTLE;
        end else if (evt[KEY_DINC]) begin
          dir_inc_n = 1'b1;
          state_n   = READ;
        end else if (evt[KEY_DDEC]) begin
          dir_inc_n = 1'b0;
          state_n   = READ;
        end
      end
      READ: begin
        din_n   = dir_inc ? dout + DATA_W'(1) : dout - DATA_W'(1);
        we_n    = 1'b1;
        state_n = WRITE;
      end
      WRITE: begin
        state_n = SETTLE;
      end
      SETTLE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State and registered RAM command outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a       <= '0;
      din     <= '0;
      we      <= 1'b0;
      dir_inc <= 1'b0;
    end else begin
      state   <= state_n;
      a       <= a_n;
      din     <= din_n;
      we      <= we_n;
      dir_inc <= dir_inc_n;
    end
  end

endmodule

// File: tb/tb_key_controller.sv
// Directed bench for key_controller with a 16x8 old-data read-during-write RAM.
module tb_key_controller;

  logic       clk;
  logic       rst_n;
  logic [3:0] KEY;
  logic [7:0] dout;
  logic [3:0] a;
  logic [7:0] din;
  logic       we;

  logic [7:0] mem [0:15];
  logic       poke_en;
  logic [3:0] poke_addr;
  logic [7:0] poke_data;

  int checks = 0;
  int errors = 0;
  int cyc;
  int we_cnt;
  int we_first;
  logic [3:0] we_a;
  logic [7:0] we_din;
  logic [7:0] dlog [0:63];

  key_controller #(
    .DEBOUNCE_CYCLES (4),
    .REPEAT_DELAY    (20),
    .REPEAT_PERIOD   (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .KEY   (KEY),
    .dout  (dout),
    .a     (a),
    .din   (din),
    .we    (we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM: registered read returns old data during a write
  always @(posedge clk) begin
    if (poke_en) mem[poke_addr] <= poke_data;
    else if (we) mem[a] <= din;
    dout <= mem[a];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc < 64) dlog[cyc] = dout;
      if (we === 1'b1) begin
        we_cnt++;
        if (we_cnt == 1) begin
          we_first = cyc;
          we_a     = a;
          we_din   = din;
        end
      end
    end
  endtask

  task automatic clear_log();
    cyc      = 0;
    we_cnt   = 0;
    we_first = -1;
  endtask

  task automatic press(input int k, input int hold);
    clear_log();
    KEY[k] = 1'b0;
    step(hold);
    KEY = 4'hF;
    step(12);
  endtask

  task automatic poke(input logic [3:0] ad, input logic [7:0] da);
    poke_en   = 1'b1;
    poke_addr = ad;
    poke_data = da;
    step(1);
    poke_en = 1'b0;
  endtask

  initial begin
    KEY     = 4'hF;
    rst_n   = 1'b0;
    poke_en = 1'b0;
    poke_addr = '0;
    poke_data = '0;
    clear_log();
    step(2);
    poke(4'h0, 8'h3C);
    check("reset_a", 32'(a), 32'h0);
    check("reset_din", 32'(din), 32'h0);
    check("reset_we", 32'(we), 32'h0);
    rst_n = 1'b1;
    step(3);

    // Clean data+1 at address 0: accepted after edge 6, WRITE at 8, new dout at 10
    press(0, 15);
    check("inc_we_count", 32'(we_cnt), 32'd1);
    check("inc_we_cycle", 32'(we_first), 32'd8);
    check("inc_we_a", 32'(we_a), 32'h0);
    check("inc_we_din", 32'(we_din), 32'h3D);
    check("inc_dout_old", 32'(dlog[9]), 32'h3C);
    check("inc_dout_new", 32'(dlog[10]), 32'h3D);
    check("inc_mem0", 32'(mem[0]), 32'h3D);

    // Address wrap both directions, never writing
    press(3, 12);
    check("adec_wrap_a", 32'(a), 32'hF);
    check("adec_no_we", 32'(we_cnt), 32'd0);
    press(2, 12);
    check("ainc_wrap_a", 32'(a), 32'h0);
    check("ainc_no_we", 32'(we_cnt), 32'd0);
    press(3, 12);
    check("adec_again_a", 32'(a), 32'hF);
    for (int i = 0; i < 6; i++) press(2, 12);
    check("nav_a5", 32'(a), 32'h5);

    // Data wrap FF+1 and 00-1
    poke(4'h5, 8'hFF);
    step(2);
    press(0, 12);
    check("dinc_wrap_din", 32'(we_din), 32'h00);
    check("dinc_wrap_mem", 32'(mem[5]), 32'h00);
    poke(4'h5, 8'h00);
    step(2);
    press(1, 12);
    check("ddec_wrap_count", 32'(we_cnt), 32'd1);
    check("ddec_wrap_din", 32'(we_din), 32'hFF);
    check("ddec_wrap_mem", 32'(mem[5]), 32'hFF);

    // Bouncing press: low runs never reach 4 cycles, then held low
    poke(4'h5, 8'h10);
    step(2);
    clear_log();
    KEY[0] = 1'b0; step(1); KEY[0] = 1'b1; step(2);
    KEY[0] = 1'b0; step(3); KEY[0] = 1'b1; step(1);
    KEY[0] = 1'b0; step(2); KEY[0] = 1'b1; step(3);
    KEY[0] = 1'b0; step(1); KEY[0] = 1'b1; step(2);
    KEY[0] = 1'b0; step(3); KEY[0] = 1'b1; step(2);
    KEY[0] = 1'b0; step(15);
    KEY = 4'hF; step(12);
    check("bounce_we_count", 32'(we_cnt), 32'd1);
    check("bounce_mem5", 32'(mem[5]), 32'h11);

    // Simultaneous addr+1 and data+1: address wins, data event dropped
    clear_log();
    KEY = 4'b1010;
    step(12);
    KEY = 4'hF;
    step(12);
    check("simul_a", 32'(a), 32'h6);
    check("simul_no_we", 32'(we_cnt), 32'd0);
    check("simul_mem5", 32'(mem[5]), 32'h11);

    // Reset during WRITE abandons the modify
    poke(4'h6, 8'h42);
    step(2);
    clear_log();
    KEY[0] = 1'b0;
    step(8);
    check("rst_in_write_we", 32'(we), 32'h1);
    rst_n = 1'b0;
    #1;
    check("rst_we_drop", 32'(we), 32'h0);
    check("rst_a_zero", 32'(a), 32'h0);
    check("rst_din_zero", 32'(din), 32'h0);
    KEY = 4'hF;
    step(3);
    rst_n = 1'b1;
    clear_log();
    step(20);
    check("rst_no_write", 32'(we_cnt), 32'd0);
    check("rst_mem6", 32'(mem[6]), 32'h42);

    // Long hold of addr+1: accepted at edge 6, level released at edge 56
    clear_log();
    KEY[2] = 1'b0;
    step(50);
    KEY = 4'hF;
    step(20);
`ifdef KEY_AUTOREPEAT_EN
    check("hold_a", 32'(a), 32'h5);
`else
    check("hold_a", 32'(a), 32'h1);
`endif
    check("hold_no_we", 32'(we_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
